// File: rtl/spi_flash_responder_if.sv
// Pin and memory-port bundle for the SPI flash read responder.
// The slave modport is the responder's view; the master modport is the SPI host plus backing memory.
interface spi_flash_responder_if #(
   parameter int ADDR_W = 24
);
   logic              spi_sck;
   logic              spi_ss;
   logic              spi_mosi;
   logic              spi_miso;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport slave (
      input  spi_sck, spi_ss, spi_mosi, mem_ack, mem_rdata,
      output spi_miso, mem_req, mem_addr
   );

   modport master (
      output spi_sck, spi_ss, spi_mosi, mem_ack, mem_rdata,
      input  spi_miso, mem_req, mem_addr
   );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder for the 0x03 flash read command: decodes the address, fetches
// 32-bit words from a memory port with a one-word prefetch, and streams them out on MISO.
module spi_flash_responder #(
   parameter logic [7:0] CMD_READ    = 8'h03,
   parameter int         ADDR_W      = 24,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   spi_flash_responder_if.slave        bus,
   output logic                        busy,
   output logic                        err_underrun
);

   localparam int CNT_W = $clog2(ADDR_W + 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, FETCH, DATA, IGNORE} state_t;

   state_t             state, state_next;
   logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
   logic               sck_prev;
   logic               sck_s, ss_s, mosi_s, sck_rise, sck_fall;
   logic [CNT_W-1:0]   bit_cnt;
   logic [ADDR_W-1:0]  addr_sr, addr_next;
   logic [31:0]        shifter, pf_buf;
   logic [5:0]         bits_left;
   logic               pf_valid, pf_pending;
   logic               shift_in, cnt_clear, issue_first, take_first;
   logic               shift_out, reload, underrun;

   // SS synchronisers reset to the deselected level so release never fakes a select
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sck_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_ss};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
         sck_prev  <= sck_s;
      end
   end

   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_prev;
   assign sck_fall  = ~sck_s & sck_prev;
   assign addr_next = {addr_sr[ADDR_W-2:0], mosi_s};
   assign busy      = (state != IDLE);

   always_comb begin
      state_next  = state;
      shift_in    = 1'b0;
      cnt_clear   = 1'b0;
      issue_first = 1'b0;
      take_first  = 1'b0;
      shift_out   = 1'b0;
      reload      = 1'b0;
      underrun    = 1'b0;
      if (ss_s) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_next = CMD;
               cnt_clear  = 1'b1;
            end
            CMD: if (sck_rise) begin
               shift_in = 1'b1;
               if (bit_cnt == CNT_W'(7)) begin
                  cnt_clear  = 1'b1;
                  state_next = (addr_next[7:0] == CMD_READ) ? ADDR : IGNORE;
               end
            end
            ADDR: if (sck_rise) begin
               shift_in = 1'b1;
               if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                  issue_first = 1'b1;
                  state_next  = FETCH;
               end
            end
            FETCH: begin
               if (sck_fall) begin
                  underrun   = 1'b1;
                  state_next = IGNORE;
               end else if (bus.mem_ack) begin
                  take_first = 1'b1;
                  state_next = DATA;
               end
            end
            DATA: if (sck_fall) begin
               // An empty shifter rolls over to the prefetched word, or the burst is lost
               if (bits_left != 6'd0) begin
                  shift_out = 1'b1;
               end else if (pf_valid) begin
                  reload = 1'b1;
               end else begin
                  underrun   = 1'b1;
                  state_next = IGNORE;
               end
            end
            IGNORE: state_next = IGNORE;
            default: state_next = IDLE;
         endcase
      end
   end

   // A deselect or underrun flushes the read path; otherwise one memory request is kept in flight
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         addr_sr      <= '0;
         shifter      <= '0;
         pf_buf       <= '0;
         bits_left    <= '0;
         pf_valid     <= 1'b0;
         pf_pending   <= 1'b0;
         bus.spi_miso <= 1'b0;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
         err_underrun <= 1'b0;
      end else begin
         state        <= state_next;
         err_underrun <= underrun;
         if (cnt_clear) begin
            bit_cnt <= '0;
         end else if (shift_in) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (shift_in) begin
            addr_sr <= addr_next;
         end
         if (ss_s || underrun) begin
            bus.spi_miso <= 1'b0;
            bus.mem_req  <= 1'b0;
            pf_valid     <= 1'b0;
            pf_pending   <= 1'b0;
            bits_left    <= '0;
         end else begin
            if (issue_first) begin
               bus.mem_addr <= addr_next & ~ADDR_W'(3);
               bus.mem_req  <= 1'b1;
            end
            if (take_first) begin
               shifter      <= bus.mem_rdata;
               bits_left    <= 6'd32;
               bus.mem_req  <= 1'b0;
               bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
               pf_pending   <= 1'b1;
            end
            if (state == DATA) begin
               if (bus.mem_req && bus.mem_ack) begin
                  pf_buf      <= bus.mem_rdata;
                  pf_valid    <= 1'b1;
                  bus.mem_req <= 1'b0;
               end else if (pf_pending && !bus.mem_req) begin
                  bus.mem_req <= 1'b1;
                  pf_pending  <= 1'b0;
               end
            end
            if (shift_out) begin
               bus.spi_miso <= shifter[31];
               shifter      <= {shifter[30:0], 1'b0};
               bits_left    <= bits_left - 6'd1;
            end
            if (reload) begin
               bus.spi_miso <= pf_buf[31];
               shifter      <= {pf_buf[30:0], 1'b0};
               bits_left    <= 6'd31;
               pf_valid     <= 1'b0;
               bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
               pf_pending   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: an SPI host and a backing memory drive the
// responder, and received words and request addresses are compared with a word-level model.
module tb_spi_flash_responder;

   localparam int H = 8;

   logic clock = 1'b0;
   logic reset;
   logic busy;
   logic err_underrun;

   int checks   = 0;
   int failures = 0;
   int mem_lat  = 2;
   int err_count = 0;

   logic [23:0] req_q[$];
   logic [31:0] mem[logic [23:0]];
   logic        rx_bits[$];

   spi_flash_responder_if bus();

   spi_flash_responder dut (
      .clock(clock),
      .reset(reset),
      .bus(bus),
      .busy(busy),
      .err_underrun(err_underrun)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (err_underrun === 1'b1) err_count++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "[TB] watchdog");
   end

   // Backing memory contents: explicit entries, otherwise a fixed address-derived pattern
   function automatic logic [31:0] mem_word(input logic [23:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[7:0] ^ 8'hC3, a};
   endfunction

   // Backing memory: logs every request and answers after mem_lat cycles
   initial begin
      logic [23:0] a;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (bus.mem_req === 1'b1) begin
            a = bus.mem_addr;
            req_q.push_back(a);
            repeat (mem_lat - 1) @(negedge clock);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word(a);
            @(negedge clock);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
         end
      end
   end

   task automatic half();
      repeat (H) @(negedge clock);
   endtask

   task automatic spi_start();
      bus.spi_ss = 1'b0;
      half();
   endtask

   task automatic spi_send(input logic [31:0] val, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.spi_mosi = val[i];
         half();
         bus.spi_sck = 1'b1;
         half();
         bus.spi_sck = 1'b0;
      end
   endtask

   // MISO is sampled just before each rising edge; the final edge stays high until deselect
   task automatic spi_read(input int nbits);
      rx_bits.delete();
      for (int i = 0; i < nbits; i++) begin
         half();
         rx_bits.push_back(bus.spi_miso);
         bus.spi_sck = 1'b1;
         half();
         if (i != nbits - 1) bus.spi_sck = 1'b0;
      end
   endtask

   task automatic spi_end();
      half();
      bus.spi_ss = 1'b1;
      repeat (4) @(negedge clock);
      bus.spi_sck  = 1'b0;
      bus.spi_mosi = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   function automatic logic [31:0] rx_word(input int k);
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 32; j++) w = {w[30:0], rx_bits[32*k + j]};
      return w;
   endfunction

   task automatic test_reset();
      reset        = 1'b0;
      bus.spi_ss   = 1'b1;
      bus.spi_sck  = 1'b0;
      bus.spi_mosi = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%0b exp=0", bus.spi_miso); end
      checks++;
      if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
      checks++;
      if (bus.mem_addr !== 24'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=000000", bus.mem_addr); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++;
      if (err_underrun !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_underrun); end
      reset = 1'b1;
      repeat (6) @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_basic_read();
      int rb = req_q.size();
      int eb = err_count;
      mem[24'h000010] = 32'hDEADBEEF;
      mem_lat = 2;
      spi_start();
      spi_send(32'h03, 8);
      spi_send(32'h000010, 24);
      spi_read(32);
      spi_end();
      checks++;
      if (rx_word(0) !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_word got=%h exp=deadbeef", rx_word(0)); end
      checks++;
      if (req_q.size() - rb != 2) begin failures++; $display("FAIL basic_req_count got=%0d exp=2", req_q.size() - rb); end
      else begin
         checks++;
         if (req_q[rb] !== 24'h000010) begin failures++; $display("FAIL basic_req0 got=%h exp=000010", req_q[rb]); end
         checks++;
         if (req_q[rb+1] !== 24'h000014) begin failures++; $display("FAIL basic_req1 got=%h exp=000014", req_q[rb+1]); end
      end
      checks++;
      if (err_count != eb) begin failures++; $display("FAIL basic_err got=%0d exp=0", err_count - eb); end
   endtask

   task automatic test_burst_wrap();
      int rb = req_q.size();
      mem[24'hFFFFFC] = 32'hA5A5A5A5;
      mem[24'h000000] = 32'h12345678;
      spi_start();
      spi_send(32'h03, 8);
      spi_send(32'hFFFFFC, 24);
      spi_read(64);
      spi_end();
      checks++;
      if (rx_word(0) !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap_word0 got=%h exp=a5a5a5a5", rx_word(0)); end
      checks++;
      if (rx_word(1) !== 32'h12345678) begin failures++; $display("FAIL wrap_word1 got=%h exp=12345678", rx_word(1)); end
      checks++;
      if (req_q.size() - rb != 3) begin failures++; $display("FAIL wrap_req_count got=%0d exp=3", req_q.size() - rb); end
      else begin
         checks++;
         if (req_q[rb+1] !== 24'h000000) begin failures++; $display("FAIL wrap_req1 got=%h exp=000000", req_q[rb+1]); end
         checks++;
         if (req_q[rb+2] !== 24'h000004) begin failures++; $display("FAIL wrap_req2 got=%h exp=000004", req_q[rb+2]); end
      end
   endtask

   task automatic test_unsupported();
      int rb = req_q.size();
      int ones = 0;
      spi_start();
      spi_send(32'h0B, 8);
      spi_send(32'h123456, 24);
      spi_read(16);
      foreach (rx_bits[i]) if (rx_bits[i] !== 1'b0) ones++;
      checks++;
      if (ones != 0) begin failures++; $display("FAIL unsup_miso got=%0d_nonzero_bits exp=0", ones); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL unsup_busy_active got=%0b exp=1", busy); end
      spi_end();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL unsup_busy_after got=%0b exp=0", busy); end
      checks++;
      if (req_q.size() != rb) begin failures++; $display("FAIL unsup_req_count got=%0d exp=0", req_q.size() - rb); end
   endtask

   task automatic test_underrun();
      int rb = req_q.size();
      int eb = err_count;
      int ones = 0;
      mem_lat = 40;
      spi_start();
      spi_send(32'h03, 8);
      spi_send(32'h000040, 24);
      spi_read(32);
      foreach (rx_bits[i]) if (rx_bits[i] !== 1'b0) ones++;
      checks++;
      if (ones != 0) begin failures++; $display("FAIL underrun_miso got=%0d_nonzero_bits exp=0", ones); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL underrun_busy got=%0b exp=1", busy); end
      spi_end();
      repeat (60) @(negedge clock);
      checks++;
      if (err_count - eb != 1) begin failures++; $display("FAIL underrun_pulses got=%0d exp=1", err_count - eb); end
      checks++;
      if (req_q.size() - rb != 1) begin failures++; $display("FAIL underrun_req_count got=%0d exp=1", req_q.size() - rb); end
      checks++;
      if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL underrun_idle got=req%0b_busy%0b exp=req0_busy0", bus.mem_req, busy);
      end
      mem_lat = 2;
   endtask

   task automatic test_early_ss();
      int rb = req_q.size();
      logic [23:0] a;
      logic [31:0] w;
      spi_start();
      spi_send(32'h03, 8);
      spi_send(32'hABC, 12);
      bus.spi_ss = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL early_busy got=%0b exp=0", busy); end
      repeat (8) @(negedge clock);
      checks++;
      if (req_q.size() != rb) begin failures++; $display("FAIL early_req_count got=%0d exp=0", req_q.size() - rb); end
      a = 24'($urandom) & 24'hFFFFFC;
      w = $urandom;
      mem[a] = w;
      spi_start();
      spi_send(32'h03, 8);
      spi_send({8'h00, a}, 24);
      spi_read(32);
      spi_end();
      checks++;
      if (rx_word(0) !== w) begin failures++; $display("FAIL early_next_word got=%h exp=%h", rx_word(0), w); end
   endtask

   // Model: a burst of n words from address A is mem[(A & ~3) + 4k] for k = 0..n-1, modulo 2^24
   task automatic test_random_bursts();
      for (int it = 0; it < 6; it++) begin
         int rb = req_q.size();
         int eb = err_count;
         int n = $urandom_range(1, 3);
         logic [23:0] addr = 24'($urandom);
         logic [23:0] base_a = addr & 24'hFFFFFC;
         logic [23:0] exp_a[$];
         logic [31:0] exp_w[$];
         mem_lat = $urandom_range(1, 3);
         for (int k = 0; k <= n; k++) begin
            logic [23:0] ak = base_a + 24'(4 * k);
            mem[ak] = $urandom;
            exp_a.push_back(ak);
            exp_w.push_back(mem[ak]);
         end
         spi_start();
         spi_send(32'h03, 8);
         spi_send({8'h00, addr}, 24);
         spi_read(32 * n);
         spi_end();
         for (int k = 0; k < n; k++) begin
            checks++;
            if (rx_word(k) !== exp_w[k]) begin
               failures++; $display("FAIL rand%0d_word%0d got=%h exp=%h", it, k, rx_word(k), exp_w[k]);
            end
         end
         checks++;
         if (req_q.size() - rb != n + 1) begin
            failures++; $display("FAIL rand%0d_req_count got=%0d exp=%0d", it, req_q.size() - rb, n + 1);
         end else begin
            for (int k = 0; k <= n; k++) begin
               checks++;
               if (req_q[rb+k] !== exp_a[k]) begin
                  failures++; $display("FAIL rand%0d_req%0d got=%h exp=%h", it, k, req_q[rb+k], exp_a[k]);
               end
            end
         end
         checks++;
         if (err_count != eb) begin failures++; $display("FAIL rand%0d_err got=%0d exp=0", it, err_count - eb); end
      end
      mem_lat = 2;
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] w;
      mem_lat = 2;
      spi_start();
      spi_send(32'h03, 8);
      spi_send(32'h000100, 24);
      spi_read(10);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.spi_miso !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 24'h0 || busy !== 1'b0 || err_underrun !== 1'b0) begin
         failures++;
         $display("FAIL midreset_outputs got=miso%0b_req%0b_addr%h_busy%0b_err%0b exp=all_zero",
                  bus.spi_miso, bus.mem_req, bus.mem_addr, busy, err_underrun);
      end
      bus.spi_ss  = 1'b1;
      bus.spi_sck = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (8) @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%0b exp=0", busy); end
      w = $urandom;
      mem[24'h000200] = w;
      spi_start();
      spi_send(32'h03, 8);
      spi_send(32'h000200, 24);
      spi_read(32);
      spi_end();
      checks++;
      if (rx_word(0) !== w) begin failures++; $display("FAIL midreset_next_word got=%h exp=%h", rx_word(0), w); end
   endtask

   initial begin
      $display("[TB] spi_flash_responder bench start");
      test_reset();
      test_basic_read();
      test_burst_wrap();
      test_unsupported();
      test_underrun();
      test_early_ss();
      test_random_bursts();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI responder (slave end) for the flash read path. It sits on the SPI pins driven by the APB SPI master, oversamples SCK, SS and MOSI with the system clock, and decodes the standard read command (0x03 + 24-bit address).
- It fetches 32-bit words from a backing-memory port and shifts them out on MISO, MSB first.
- Reads burst continuously, auto-incrementing by one word, until SS deasserts.

Parameters:
- CMD_READ, 8'h03, only command opcode served; any other opcode is ignored.
- ADDR_W, 24, SPI address width and mem_addr width.
- SYNC_STAGES, 2, synchroniser depth for spi_sck, spi_ss and spi_mosi (minimum 2).

Ports:
- clock  in  1  system clock; must be at least 8x the SCK frequency.
- reset  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_ss  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data; sampled on SCK rising edge.
- spi_miso  out  1  slave-out data; changes after SCK falling edge.
- mem_req  out  1  memory read request; held until mem_ack.
- mem_addr  out  ADDR_W  word-aligned byte address of the request; bits [1:0]=0.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word; bit 31 is sent first.
- busy  out  1  high whenever the FSM is not IDLE.
- err_underrun  out  1  one-cycle pulse when a data bit is due but no word is loaded.

Behaviour:
- Reset (async assert, sync release) values:
  - spi_miso=0, mem_req=0, mem_addr=0, busy=0, err_underrun=0.
  - FSM=IDLE; all shifters, counters and valid flags cleared.
- Input synchronisation:
  - SCK, SS and MOSI pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised SCK (rise = prev 0, now 1).
  - All decoding uses synchronised values.
  - Consequence: latency from a pin edge to internal action is SYNC_STAGES+1 clocks.
- SS high (synchronised), from any state:
  - Next cycle: FSM=IDLE, mem_req=0, spi_miso=0, buffers invalidated.
  - An outstanding mem_ack arriving later is discarded.
- FSM states and transitions:
  - IDLE: on SS low -> CMD, bit counter cleared.
  - CMD: shift MOSI in on each SCK rise, MSB first. After the 8th bit: opcode==CMD_READ -> ADDR, otherwise -> IGNORE.
  - ADDR: shift in 24 bits, MSB first. After the 24th rise:
    - mem_addr <= {addr[23:2],2'b00} (low two address bits ignored).
    - mem_req=1 -> FETCH.
  - FETCH: wait for mem_ack.
    - On ack: shifter<=mem_rdata, shifter_valid=1.
    - Then immediately issue a prefetch request at mem_addr+4 into the prefetch buffer -> DATA.
    - If an SCK fall arrives while still in FETCH: err_underrun pulse, spi_miso=0 -> IGNORE.
  - DATA, on each SCK fall:
    - spi_miso <= current bit; bit counter increments.
    - The first fall after the address phase drives bit 31.
    - The fall following the 32nd bit's rise loads the prefetch buffer into the shifter, drives its bit 31, and issues the next prefetch at +4.
    - If the prefetch buffer is not valid at that fall: err_underrun pulse, spi_miso=0 -> IGNORE.
  - IGNORE: spi_miso=0; MOSI and SCK are ignored until SS goes high.
- Address arithmetic is modulo 2^ADDR_W: 24'hFFFFFC + 4 = 24'h000000.
- Only one request is outstanding at a time.
  - mem_req deasserts in the cycle after mem_ack.
  - The prefetch buffer holds one word.
- SCK edges while in IDLE, or in the same cycle SS deasserts, are ignored.
- spi_miso holds its value between falls; no high-Z output.

Test Plan:
- Reset mid-burst: assert reset during DATA -> all outputs 0 immediately; FSM=IDLE after release; a new transaction works normally.
- Basic read: SS low, send 03 00 00 10, mem returns 32'hDEADBEEF at addr 0x10 with 2-cycle latency, 32 SCKs -> MISO bits read back as 0xDEADBEEF; one request to 0x10 then one prefetch to 0x14.
- Burst with wrap: address 0xFFFFFC, 64 data SCKs, mem returns A5A5A5A5 then 12345678 -> both words received in order; second request has mem_addr=0x000000.
- Unsupported command: opcode 0x0B followed by 24 address bits -> no mem_req, MISO stays 0, busy=1 until SS high, then busy=0.
- Underrun: mem_ack delayed beyond the first data SCK fall -> err_underrun pulses once, MISO=0 for the remainder, late ack ignored.
- Early SS release: SS deasserts after 12 address bits -> IDLE within SYNC_STAGES+2 cycles, no mem_req; next full 03 transaction returns correct data.
